xbee_api_tx: RTL and testbench

//  Fabric-side xBee API-frame transmitter; successor to the fixed MSS UART pass-through.

---
 rtl/xbee_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/xbee_api_tx.sv | 133 +++++++++++++
 tb/tb_xbee_api_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbee_pkg.sv
// Shared constants, frame state encoding and reserved-byte test for the xBee API transmitter.
package xbee_pkg;

    localparam logic [7:0] XBEE_DELIM = 8'h7E;
    localparam logic [7:0] XBEE_ESC   = 8'h7D;
    localparam logic [7:0] XBEE_XOR   = 8'h20;
    localparam logic [7:0] XBEE_XON   = 8'h11;
    localparam logic [7:0] XBEE_XOFF  = 8'h13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELIM,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DONE
    } frame_state_e;

    function automatic logic is_reserved(input logic [7:0] b);
        return (b == XBEE_DELIM) || (b == XBEE_ESC) || (b == XBEE_XON) || (b == XBEE_XOFF);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1/8N2 byte serialiser; the final stop-bit cycle is the idle cycle in which the
// next byte is accepted, so back-to-back bytes leave no gap on the line.
module uart_tx_byte #(
    parameter int DIV       = 2,
    parameter int STOP_BITS = 1
) (
    input  logic       FAB_CLK,
    input  logic       FAB_RESET,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    output logic       TXD
);

    localparam int             CW     = $clog2(DIV);
    localparam logic [CW-1:0]  DIV_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0]  DIV_M2 = CW'(DIV - 2);
    localparam logic [3:0]     LAST_B = 4'(8 + STOP_BITS);

    logic          busy_q;
    logic          txd_q;
    logic [CW-1:0] div_q;
    logic [3:0]    bit_q;
    logic [8:0]    shf_q;
    logic          last_bit;

    assign READY    = !busy_q;
    assign TXD      = txd_q;
    assign last_bit = (bit_q == LAST_B);

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            busy_q <= 1'b0;
            txd_q  <= 1'b1;
            div_q  <= '0;
            bit_q  <= '0;
            shf_q  <= '1;
        end else if (!busy_q) begin
            if (VALID) begin
                busy_q <= 1'b1;
                txd_q  <= 1'b0;
                shf_q  <= {1'b1, DATA};
                div_q  <= '0;
                bit_q  <= '0;
            end
        end else if (div_q == (last_bit ? DIV_M2 : DIV_M1)) begin
            div_q <= '0;
            // Ones shift in behind the data so the stop bits come out for free.
            if (last_bit) begin
                busy_q <= 1'b0;
            end else begin
                bit_q <= bit_q + 4'd1;
                txd_q <= shf_q[0];
                shf_q <= {1'b1, shf_q[8:1]};
            end
        end else begin
            div_q <= div_q + CW'(1);
        end
    end

endmodule

// File: rtl/xbee_api_tx.sv
// xBee API frame transmitter: buffers payload bytes and on SEND emits
// 7E, LEN_H, LEN_L, payload, checksum, optionally with API-mode-2 escaping.
module xbee_api_tx
    import xbee_pkg::*;
#(
    parameter int CLK_HZ    = 40000000,
    parameter int BAUD      = 9600,
    parameter int DEPTH     = 64,
    parameter int STOP_BITS = 1,
    parameter int ESCAPED   = 0
) (
    input  logic       FAB_CLK,
    input  logic       FAB_RESET,
    input  logic [7:0] WR_DATA,
    input  logic       WR_VALID,
    output logic       WR_READY,
    input  logic       SEND,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       UART_TXD
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] rd_q;
    logic [7:0]    sum_q;
    frame_state_e  st_q;
    logic          busy_q, done_q, esc_q, sent_q;

    logic          wr_fire;
    logic [AW-1:0] wr_addr;
    logic [15:0]   len_w;
    logic [7:0]    raw, tx_data;
    logic          need_esc, tx_valid, tx_ready, tx_take, byte_done;

    assign WR_READY   = !busy_q && (cnt_q < CW'(DEPTH));
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign wr_fire    = WR_VALID && WR_READY;
    // The DONE cycle clears the buffer, so a write landing there starts it afresh.
    assign wr_addr    = (st_q == ST_DONE) ? '0 : cnt_q[AW-1:0];
    assign len_w      = 16'(cnt_q);

    always_comb begin
        raw = XBEE_DELIM;
        case (st_q)
            ST_LEN_H:   raw = len_w[15:8];
            ST_LEN_L:   raw = len_w[7:0];
            ST_PAYLOAD: raw = mem_q[rd_q];
            ST_CSUM:    raw = 8'hFF - sum_q;
            default:    raw = XBEE_DELIM;
        endcase
    end

    assign need_esc  = (ESCAPED != 0) && (st_q != ST_DELIM) && is_reserved(raw);
    assign tx_data   = esc_q ? (raw ^ XBEE_XOR) : (need_esc ? XBEE_ESC : raw);
    assign tx_valid  = (st_q == ST_DELIM) || (st_q == ST_LEN_H) || (st_q == ST_LEN_L) ||
                       (st_q == ST_PAYLOAD) || ((st_q == ST_CSUM) && !sent_q);
    assign tx_take   = tx_valid && tx_ready;
    assign byte_done = tx_take && (esc_q || !need_esc);

    always_ff @(posedge FAB_CLK) begin
        if (wr_fire) mem_q[wr_addr] <= WR_DATA;
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            rd_q   <= '0;
            sum_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            esc_q  <= 1'b0;
            sent_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_fire) begin
                cnt_q <= cnt_q + CW'(1);
                sum_q <= sum_q + WR_DATA;
            end
            if (tx_take) esc_q <= need_esc && !esc_q;
            case (st_q)
                ST_IDLE: if (SEND && ((cnt_q != '0) || wr_fire)) begin
                    st_q   <= ST_DELIM;
                    busy_q <= 1'b1;
                    rd_q   <= '0;
                    sent_q <= 1'b0;
                end
                ST_DELIM: if (byte_done) st_q <= ST_LEN_H;
                ST_LEN_H: if (byte_done) st_q <= ST_LEN_L;
                ST_LEN_L: if (byte_done) st_q <= ST_PAYLOAD;
                ST_PAYLOAD: if (byte_done) begin
                    if ({1'b0, rd_q} == cnt_q - CW'(1)) st_q <= ST_CSUM;
                    else                                 rd_q <= rd_q + AW'(1);
                end
                ST_CSUM: begin
                    // READY returning marks the final stop-bit cycle of the checksum.
                    if (byte_done) begin
                        sent_q <= 1'b1;
                    end else if (sent_q && tx_ready) begin
                        st_q   <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    st_q  <= ST_IDLE;
                    cnt_q <= wr_fire ? CW'(1) : '0;
                    sum_q <= wr_fire ? WR_DATA : 8'h00;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV       (DIV),
        .STOP_BITS (STOP_BITS)
    ) u_uart (
        .FAB_CLK   (FAB_CLK),
        .FAB_RESET (FAB_RESET),
        .DATA      (tx_data),
        .VALID     (tx_valid),
        .READY     (tx_ready),
        .TXD       (UART_TXD)
    );

endmodule

// File: tb/tb_xbee_api_tx.sv
// Bench for xbee_api_tx: instance 0 is plain/1 stop/depth 4, instance 1 is escaped/2 stop/depth 32.
module tb_xbee_api_tx;

    localparam int DIVC = 10;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, wr_valid, send, wr_ready, busy, done, txd;
    logic [7:0] wr_data [2];

    xbee_api_tx #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(4), .STOP_BITS(1), .ESCAPED(0)) dut0 (
        .FAB_CLK(clk), .FAB_RESET(rst[0]), .WR_DATA(wr_data[0]), .WR_VALID(wr_valid[0]),
        .WR_READY(wr_ready[0]), .SEND(send[0]), .BUSY(busy[0]), .FRAME_DONE(done[0]),
        .UART_TXD(txd[0]));

    xbee_api_tx #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(32), .STOP_BITS(2), .ESCAPED(1)) dut1 (
        .FAB_CLK(clk), .FAB_RESET(rst[1]), .WR_DATA(wr_data[1]), .WR_VALID(wr_valid[1]),
        .WR_READY(wr_ready[1]), .SEND(send[1]), .BUSY(busy[1]), .FRAME_DONE(done[1]),
        .UART_TXD(txd[1]));

    function automatic int nb(input int i);
        return (i == 0) ? 10 : 11;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples each bit mid-period and logs byte values and start cycles.
    logic       rx_act [2];
    int         rx_cnt [2];
    int         bstart [2];
    logic [7:0] rx_sh  [2];
    logic [7:0] rxb    [2][64];
    int         rxs    [2][64];
    int         rxn    [2];
    int         ferr   [2];
    int         done_cnt [2];
    int         done_cyc [2];

    always @(negedge clk) begin
        int k;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                done_cnt[i] = done_cnt[i] + 1;
                done_cyc[i] = cyc;
            end
            if (!rx_act[i]) begin
                if (txd[i] === 1'b0) begin
                    rx_act[i] = 1'b1;
                    rx_cnt[i] = 0;
                    bstart[i] = cyc;
                end
            end else begin
                rx_cnt[i] = rx_cnt[i] + 1;
                if (rx_cnt[i] % DIVC == DIVC / 2) begin
                    k = rx_cnt[i] / DIVC;
                    if (k == 0) begin
                        if (txd[i] !== 1'b0) ferr[i] = ferr[i] + 1;
                    end else if (k <= 8) begin
                        rx_sh[i][k-1] = txd[i];
                    end else begin
                        if (txd[i] !== 1'b1) ferr[i] = ferr[i] + 1;
                        if (k == nb(i) - 1) begin
                            if (rxn[i] < 64) begin
                                rxb[i][rxn[i]] = rx_sh[i];
                                rxs[i][rxn[i]] = bstart[i];
                                rxn[i] = rxn[i] + 1;
                            end
                            rx_act[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input int i, input logic [7:0] b, input logic with_send);
        wr_data[i]  = b;
        wr_valid[i] = 1'b1;
        send[i]     = with_send;
        @(posedge clk);
        #1;
        wr_valid[i] = 1'b0;
        send[i]     = 1'b0;
    endtask

    task automatic pulse_send(input int i);
        send[i] = 1'b1;
        @(posedge clk);
        #1;
        send[i] = 1'b0;
    endtask

    task automatic start_capture(input int i);
        rxn[i]      = 0;
        ferr[i]     = 0;
        done_cnt[i] = 0;
    endtask

    task automatic check_frame(input int i, input logic [319:0] ex, input int nex,
                               input int sc, input string tag);
        int   last;
        logic bad;
        for (int c = 0; c < 4000 && done_cnt[i] == 0; c++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        chk({tag, " done pulses"}, done_cnt[i], 1);
        chk({tag, " byte count"}, rxn[i], nex);
        for (int k = 0; k < nex && k < rxn[i]; k++)
            chk($sformatf("%s byte%0d", tag, k), rxb[i][k], ex[8*(nex-1-k) +: 8]);
        if (rxn[i] > 0) begin
            last = rxn[i] - 1;
            chk({tag, " first start cycle"}, rxs[i][0], sc + 2);
            bad = 1'b0;
            for (int k = 1; k <= last; k++)
                if (rxs[i][k] - rxs[i][k-1] != DIVC * nb(i)) bad = 1'b1;
            chk({tag, " byte spacing"}, bad, 0);
            chk({tag, " done cycle"}, done_cyc[i], rxs[i][last] + DIVC * nb(i));
        end
        chk({tag, " framing"}, ferr[i], 0);
    endtask

    typedef struct {
        int           inst;
        int           npay;
        logic [159:0] pay;
        int           nexp;
        logic [319:0] exp;
        logic         sw;
    } vec_t;

    vec_t vt [6];
    int   sc;
    int   ii;
    logic bad;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rx_act[i] = 1'b0; rxn[i] = 0; ferr[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
            wr_data[i] = 8'h00;
        end
        vt[0] = '{0, 2, {8'h01, 8'h02}, 6, {8'h7E, 8'h00, 8'h02, 8'h01, 8'h02, 8'hFC}, 1'b0};
        vt[1] = '{1, 2, {8'h7E, 8'h11}, 8,
                  {8'h7E, 8'h00, 8'h02, 8'h7D, 8'h5E, 8'h7D, 8'h31, 8'h70}, 1'b0};
        vt[2] = '{1, 1, {8'h6E}, 5, {8'h7E, 8'h00, 8'h01, 8'h6E, 8'h91}, 1'b1};
        vt[3] = '{1, 1, {8'h81}, 6, {8'h7E, 8'h00, 8'h01, 8'h81, 8'h7D, 8'h5E}, 1'b0};
        vt[4] = '{1, 17, 160'h0, 22, {8'h7E, 8'h00, 8'h7D, 8'h31, 136'h0, 8'hFF}, 1'b0};
        vt[5] = '{0, 4, {8'hA5, 8'h5A, 8'h13, 8'h7E}, 8,
                  {8'h7E, 8'h00, 8'h04, 8'hA5, 8'h5A, 8'h13, 8'h7E, 8'h6F}, 1'b1};

        rst = 2'b11; wr_valid = 2'b00; send = 2'b00;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset txd%0d", i), txd[i], 1);
            chk($sformatf("reset busy%0d", i), busy[i], 0);
            chk($sformatf("reset done%0d", i), done[i], 0);
            chk($sformatf("reset wr_ready%0d", i), wr_ready[i], 1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;

        // SEND with an empty buffer must be ignored.
        pulse_send(0);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
        end
        chk("empty send ignored", bad, 0);

        foreach (vt[n]) begin
            ii = vt[n].inst;
            start_capture(ii);
            sc = 0;
            for (int k = 0; k < vt[n].npay; k++) begin
                if (k == vt[n].npay - 1 && vt[n].sw) sc = cyc;
                wr(ii, vt[n].pay[8*(vt[n].npay-1-k) +: 8], (k == vt[n].npay - 1) && vt[n].sw);
            end
            if (!vt[n].sw) begin
                sc = cyc;
                pulse_send(ii);
            end
            chk($sformatf("vec%0d busy at t+1", n), busy[ii], 1);
            chk($sformatf("vec%0d txd at t+1", n), txd[ii], 1);
            check_frame(ii, vt[n].exp, vt[n].nexp, sc, $sformatf("vec%0d", n));
        end

        // Buffer full: fifth byte dropped; SEND during BUSY ignored.
        start_capture(0);
        for (int k = 0; k < 5; k++) begin
            wr(0, 8'((k + 1) * 16), 1'b0);
            if (k == 3) chk("full wr_ready", wr_ready[0], 0);
        end
        sc = cyc;
        pulse_send(0);
        repeat (150) @(posedge clk);
        #1;
        pulse_send(0);
        check_frame(0, {8'h7E, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h5F}, 8, sc, "full");
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
        end
        chk("no frame from send while busy", bad, 0);

        // Writes offered during BUSY must not be taken.
        start_capture(0);
        sc = cyc;
        wr(0, 8'h01, 1'b1);
        wr_data[0] = 8'hEE; wr_valid[0] = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (wr_ready[0] !== 1'b0) bad = 1'b1;
        end
        wr_valid[0] = 1'b0;
        chk("wr_ready low while busy", bad, 0);
        check_frame(0, {8'h7E, 8'h00, 8'h01, 8'h01, 8'hFE}, 5, sc, "one");
        start_capture(0);
        sc = cyc;
        wr(0, 8'h02, 1'b1);
        check_frame(0, {8'h7E, 8'h00, 8'h01, 8'h02, 8'hFD}, 5, sc, "after busy writes");

        // Reset in the middle of the payload byte.
        start_capture(1);
        sc = cyc;
        wr(1, 8'h42, 1'b1);
        for (int c = 0; c < 3000 && rxn[1] < 3; c++) @(posedge clk);
        repeat (40) @(posedge clk);
        #1;
        chk("mid-frame busy", busy[1], 1);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        chk("abort txd", txd[1], 1);
        chk("abort busy", busy[1], 0);
        chk("abort wr_ready", wr_ready[1], 1);
        repeat (200) @(posedge clk);
        #1;
        start_capture(1);
        sc = cyc;
        wr(1, 8'h05, 1'b1);
        check_frame(1, {8'h7E, 8'h00, 8'h01, 8'h05, 8'hFA}, 5, sc, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
